// File: rtl/dmac_sched_pkg.sv
// rtl/dmac_sched_pkg.sv - shared types and sizes for the DMA job scheduler
package dmac_sched_pkg;

  localparam int NB_CORES_DEF      = 4;
  localparam int NB_TRANSFERS_DEF  = 8;
  localparam int CMD_WIDTH_DEF     = 64;
  localparam int TID_WIDTH_DEF     = $clog2(NB_TRANSFERS_DEF);
  localparam int CORE_ID_WIDTH_DEF = $clog2(NB_CORES_DEF);
  localparam int STAT_WIDTH        = 32;

  typedef logic [TID_WIDTH_DEF-1:0]     tid_t;
  typedef logic [CORE_ID_WIDTH_DEF-1:0] core_id_t;
  typedef logic [CMD_WIDTH_DEF-1:0]     cmd_t;

  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

endpackage

// File: rtl/dmac_rr_arbiter.sv
// rtl/dmac_rr_arbiter.sv - round-robin arbiter: one-hot grant, winner index, next pointer
module dmac_rr_arbiter
  import dmac_sched_pkg::*;
#(
  parameter int NB_CORES = NB_CORES_DEF,
  parameter int CORE_W   = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
) (
  input  logic [NB_CORES-1:0] req,
  input  logic [CORE_W-1:0]   ptr,
  output logic [NB_CORES-1:0] grant,
  output logic [CORE_W-1:0]   winner,
  output logic [CORE_W-1:0]   ptr_next,
  output logic                found
);

  int unsigned idx;

  // Scan from the pointer upward with wrap; first requester wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NB_CORES; i++) begin
      idx = (int'(ptr) + i) % NB_CORES;
      if (!found && req[idx]) begin
        found      = 1'b1;
        winner     = idx[CORE_W-1:0];
        grant[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (found) begin
      if (winner == CORE_W'(NB_CORES - 1)) ptr_next = '0;
      else                                 ptr_next = winner + CORE_W'(1);
    end
  end

endmodule

// File: rtl/dmac_job_scheduler.sv
// rtl/dmac_job_scheduler.sv - DMA command port sharing: RR arbitration, TID pool, completion events
// Optional busy-cycle statistics counter enabled by DMAC_SCHED_STATS_EN.
module dmac_job_scheduler
  import dmac_sched_pkg::*;
#(
  parameter int NB_CORES     = NB_CORES_DEF,
  parameter int NB_TRANSFERS = NB_TRANSFERS_DEF,
  parameter int CMD_WIDTH    = CMD_WIDTH_DEF,
  parameter int TID_WIDTH    = $clog2(NB_TRANSFERS)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NB_CORES-1:0]           req_valid_i,
  input  logic [NB_CORES*CMD_WIDTH-1:0] req_cmd_i,
  output logic [NB_CORES-1:0]           req_ready_o,
  output logic [TID_WIDTH-1:0]          req_tid_o,
  output logic                          cmd_valid_o,
  input  logic                          cmd_ready_i,
  output logic [CMD_WIDTH-1:0]          cmd_data_o,
  output logic [TID_WIDTH-1:0]          cmd_tid_o,
  input  logic                          done_valid_i,
  input  logic [TID_WIDTH-1:0]          done_tid_i,
  output logic [NB_CORES-1:0]           term_event_o,
  output logic                          busy_o,
  output logic                          err_o,
  output logic [STAT_WIDTH-1:0]         stat_cycles_o
);

  localparam int CORE_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

  logic [NB_TRANSFERS-1:0] busy_mask;
  logic [CORE_W-1:0]       owner_q [NB_TRANSFERS];
  logic [CORE_W-1:0]       rr_ptr;
  logic [NB_CORES-1:0]     term_q;

  logic [TID_WIDTH-1:0]    free_tid;
  logic                    pool_full;
  logic                    accept_en;
  logic                    accept;
  logic [NB_CORES-1:0]     arb_req;
  logic [NB_CORES-1:0]     arb_grant;
  logic [CORE_W-1:0]       winner;
  logic [CORE_W-1:0]       ptr_next;
  logic                    done_hit;
  logic [NB_TRANSFERS-1:0] set_vec;
  logic [NB_TRANSFERS-1:0] clr_vec;

  // Lowest free TID from the registered mask, so a TID freed this cycle is not reused yet.
  always_comb begin
    free_tid = '0;
    for (int t = NB_TRANSFERS - 1; t >= 0; t--) begin
      if (!busy_mask[t]) free_tid = TID_WIDTH'(t);
    end
  end

  assign pool_full = &busy_mask;
  assign accept_en = !pool_full && (!cmd_valid_o || cmd_ready_i);
  assign arb_req   = req_valid_i & {NB_CORES{accept_en}};

  dmac_rr_arbiter #(
    .NB_CORES (NB_CORES),
    .CORE_W   (CORE_W)
  ) u_arb (
    .req      (arb_req),
    .ptr      (rr_ptr),
    .grant    (arb_grant),
    .winner   (winner),
    .ptr_next (ptr_next),
    .found    (accept)
  );

  assign req_ready_o = arb_grant;
  assign req_tid_o   = accept ? free_tid : '0;
  assign done_hit    = done_valid_i && busy_mask[done_tid_i];

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept)   set_vec[free_tid]   = 1'b1;
    if (done_hit) clr_vec[done_tid_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_mask   <= '0;
      rr_ptr      <= '0;
      term_q      <= '0;
      err_o       <= 1'b0;
      cmd_valid_o <= 1'b0;
      cmd_data_o  <= '0;
      cmd_tid_o   <= '0;
      for (int t = 0; t < NB_TRANSFERS; t++) owner_q[t] <= '0;
    end else begin
      busy_mask <= (busy_mask | set_vec) & ~clr_vec;
      term_q    <= '0;
      if (accept) begin
        owner_q[free_tid] <= winner;
        rr_ptr            <= ptr_next;
        cmd_valid_o       <= 1'b1;
        cmd_data_o        <= req_cmd_i[int'(winner)*CMD_WIDTH +: CMD_WIDTH];
        cmd_tid_o         <= free_tid;
      end else if (cmd_ready_i) begin
        cmd_valid_o <= 1'b0;
      end
      if (done_hit)          term_q[owner_q[done_tid_i]] <= 1'b1;
      else if (done_valid_i) err_o <= 1'b1;
    end
  end

  assign term_event_o = term_q;
  assign busy_o       = (|busy_mask) | cmd_valid_o;

`ifdef DMAC_SCHED_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         stat_q <= '0;
    else if (busy_o && stat_q != STAT_MAX) stat_q <= stat_q + 1'b1;
  end

  assign stat_cycles_o = stat_q;
`else
  assign stat_cycles_o = '0;
`endif

endmodule

// File: tb/tb_dmac_job_scheduler.sv
// tb/tb_dmac_job_scheduler.sv - directed self-checking bench for dmac_job_scheduler
module tb_dmac_job_scheduler;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [255:0] req_cmd;
  logic [3:0]   req_ready;
  logic [2:0]   req_tid;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [63:0]  cmd_data;
  logic [2:0]   cmd_tid;
  logic         done_valid;
  logic [2:0]   done_tid;
  logic [3:0]   term_event;
  logic         busy;
  logic         err;
  logic [31:0]  stat_cycles;

  int checks = 0;
  int errors = 0;

  dmac_job_scheduler dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_cmd_i     (req_cmd),
    .req_ready_o   (req_ready),
    .req_tid_o     (req_tid),
    .cmd_valid_o   (cmd_valid),
    .cmd_ready_i   (cmd_ready),
    .cmd_data_o    (cmd_data),
    .cmd_tid_o     (cmd_tid),
    .done_valid_i  (done_valid),
    .done_tid_i    (done_tid),
    .term_event_o  (term_event),
    .busy_o        (busy),
    .err_o         (err),
    .stat_cycles_o (stat_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] stat_model;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)    stat_model <= 0;
    else if (busy) stat_model <= stat_model + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag);
`ifdef DMAC_SCHED_STATS_EN
    chk(tag, stat_cycles, stat_model);
`else
    chk(tag, stat_cycles, 0);
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_cmd    = '0;
    cmd_ready  = 1'b1;
    done_valid = 1'b0;
    done_tid   = '0;
    tick;
    tick;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_term", term_event, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_stat", stat_cycles, 0);
    rst_n = 1'b1;

    // 1: single request from core 0
    req_cmd[63:0] = 64'hA5;
    req_valid     = 4'b0001;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_tid", req_tid, 0);
    tick;
    req_valid = '0;
    chk("t1_cmd_valid", cmd_valid, 1);
    chk("t1_cmd_data", cmd_data, 64'hA5);
    chk("t1_cmd_tid", cmd_tid, 0);
    chk("t1_busy", busy, 1);
    done_valid = 1'b1;
    done_tid   = 3'd0;
    tick;
    done_valid = 1'b0;
    chk("t1_term", term_event, 4'b0001);
    chk("t1_busy_idle", busy, 0);
    tick;
    chk("t1_term_pulse", term_event, 0);
    chk_stats("t1_stat");

    // reset pulse to return the RR pointer to core 0
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;

    // 2: all cores request, pool fills with tids 0..7
    for (int c = 0; c < 4; c++) req_cmd[c*64 +: 64] = 64'h100 + 64'(c);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t2_ready", req_ready, 4'b0001 << (k % 4));
      chk("t2_tid", req_tid, 64'(k));
      tick;
      chk("t2_cmd_data", cmd_data, 64'h100 + 64'(k % 4));
      chk("t2_cmd_tid", cmd_tid, 64'(k));
    end
    #1;
    chk("t2_full_ready", req_ready, 0);
    chk("t2_full_busy", busy, 1);

    // 3: free tid 3 (owner core 3) while pool full
    done_valid = 1'b1;
    done_tid   = 3'd3;
    #1;
    chk("t3_no_same_cycle", req_ready, 0);
    tick;
    done_valid = 1'b0;
    chk("t3_term", term_event, 4'b1000);
    #1;
    chk("t3_ready", req_ready, 4'b0001);
    chk("t3_tid", req_tid, 3);
    tick;
    chk("t3_cmd_valid", cmd_valid, 1);
    chk("t3_cmd_data", cmd_data, 64'h100);
    chk("t3_cmd_tid", cmd_tid, 3);

    // 4: stall the output slot for 5 cycles with a free tid available
    cmd_ready  = 1'b0;
    done_valid = 1'b1;
    done_tid   = 3'd0;
    tick;
    done_valid = 1'b0;
    chk("t4_term", term_event, 4'b0001);
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("t4_ready_stall", req_ready, 0);
      chk("t4_valid_hold", cmd_valid, 1);
      chk("t4_data_hold", cmd_data, 64'h100);
      chk("t4_tid_hold", cmd_tid, 3);
      tick;
    end
    cmd_ready = 1'b1;
    #1;
    chk("t4_ready_resume", req_ready, 4'b0010);
    chk("t4_tid_resume", req_tid, 0);
    tick;
    req_valid = '0;
    chk("t4_cmd_data", cmd_data, 64'h101);
    chk("t4_cmd_tid", cmd_tid, 0);
    tick;
    chk("t4_slot_empty", cmd_valid, 0);

    // 5: done for tid 5 twice; second is for a free tid
    done_valid = 1'b1;
    done_tid   = 3'd5;
    tick;
    chk("t5_term_first", term_event, 4'b0010);
    chk("t5_err_clear", err, 0);
    tick;
    done_valid = 1'b0;
    chk("t5_err_set", err, 1);
    chk("t5_no_term", term_event, 0);
    tick;
    chk("t5_err_sticky", err, 1);
    req_valid = 4'b0100;
    #1;
    chk("t5_ready", req_ready, 4'b0100);
    chk("t5_tid", req_tid, 5);
    tick;
    req_valid = '0;
    chk("t5_cmd_tid", cmd_tid, 5);
    chk("t5_cmd_data", cmd_data, 64'h102);
    chk_stats("t5_stat");

    // 6: asynchronous reset with tids in flight
    rst_n = 1'b0;
    #1;
    chk("t6_cmd_valid", cmd_valid, 0);
    chk("t6_cmd_data", cmd_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_err", err, 0);
    chk("t6_term", term_event, 0);
    chk("t6_stat", stat_cycles, 0);
    tick;
    rst_n     = 1'b1;
    req_valid = 4'b1000;
    #1;
    chk("t6_ready", req_ready, 4'b1000);
    chk("t6_tid", req_tid, 0);
    tick;
    req_valid = '0;
    chk("t6_cmd_tid", cmd_tid, 0);
    chk("t6_cmd_data", cmd_data, 64'h103);
    tick;
    chk_stats("t6_stat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
